song_reader: RTL and testbench
==============================

# song_reader

Sequencer that sits directly upstream of the note player. It walks a synchronous song ROM one note at a time and hands each {note, duration} pair to the note player with a single-cycle load pulse. It waits for the note player's done flag before fetching the next note, and reports end-of-song with a one-cycle pulse. Four songs of up to 32 notes each are supported; a zero-duration ROM word marks an early end of song.

## Interface
- NOTES_PER_SONG, 32, maximum notes per song; index width is log2 of this value (5).
- ROM_LATENCY, 1, song ROM read latency in clocks; only the value 1 is supported.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- play  in  1  high = run or continue the song; low = pause, with no advance past the current note.
- song  in  2  song select.
- note_done  in  1  the note player's done_with_note.
- rom_addr  out  7  {song_l, note_index}; combinational from registered state.
- rom_data  in  12  {note[11:6], duration[5:0]}; valid 1 cycle after rom_addr.
- note_to_load  out  6  registered note for the note player.
- duration_to_load  out  6  registered duration in beats.
- load_new_note  out  1  one-cycle load strobe to the note player.
- song_done  out  1  one-cycle pulse at end of song.

## Operation
- Registers:
  - state: IDLE, FETCH, DECODE, LOAD, ARM, WAIT_DONE.
  - song_l[1:0]: latched song select.
  - note_index[4:0].
  - note_to_load, duration_to_load, song_done.
- Reset (asynchronous, reset_n=0):
  - state=IDLE; note_index=0; song_l=0.
  - note_to_load=0, duration_to_load=0, load_new_note=0, song_done=0, rom_addr=0.
- IDLE: note_index held at 0. If play=1: song_l<=song and go to FETCH.
- FETCH: rom_addr presents {song_l, note_index}; the ROM registers the address this edge. Go to DECODE.
- DECODE: rom_data is valid.
  - If rom_data[5:0]==0 (end marker): song_done<=1, note_index<=0, go to IDLE.
  - Else: note_to_load<=rom_data[11:6], duration_to_load<=rom_data[5:0], go to LOAD.
- LOAD: load_new_note=1 (decoded from state, exactly this cycle). Go to ARM.
- ARM: one dead cycle. note_done still reflects the previous note's counter (0) until the note player has loaded, so it is ignored here. Go to WAIT_DONE.
- WAIT_DONE: if note_done=1 and play=1:
  - note_index==31: song_done<=1, note_index<=0, go to IDLE.
  - else: note_index<=note_index+1, go to FETCH.
  - Otherwise hold.
- song_done is a registered pulse, high only in the IDLE cycle that follows the end of a song. It is cleared on every other cycle.
- Looping: if play stays high after song end, the FSM spends exactly one cycle in IDLE (song_done=1), then restarts the song at index 0.
- Pause: play=0 only blocks the WAIT_DONE advance and the IDLE start. An in-flight FETCH/DECODE/LOAD/ARM sequence still completes; the note player freezes its own counter.
- Song change: in any non-IDLE state, song != song_l forces the following, overriding all other transitions that cycle:
  - song_l<=song, note_index<=0, go to FETCH.
  - No song_done pulse is generated.
  - A LOAD already in progress still emits its pulse if the FSM is in LOAD that cycle.
- note_index never exceeds 31. There is no wrap without passing through IDLE.

## Timing
- Start latency: play sampled high in IDLE at edge N gives FETCH at N+1, DECODE at N+2, LOAD (load_new_note=1) in the cycle after edge N+3.
- Note-to-note gap: note_done seen high in WAIT_DONE at edge M gives the next load_new_note 3 cycles later (FETCH, DECODE, LOAD).
- note_to_load and duration_to_load are stable from the LOAD cycle until the next DECODE.
- End-of-song: the transition edge is followed by 1 cycle of song_done=1 in IDLE.
- reset_n asserted mid-song takes effect immediately. All outputs are at reset values before the next clk edge; no load pulse is emitted.

## Test plan
- Reset/start: reset_n low then high; song=2, play=1; ROM word at 0x40 = {note 6'd20, dur 6'd3} → rom_addr=0x40, load_new_note high exactly one cycle, 3 cycles after play is sampled, with note_to_load=20 and duration_to_load=3.
- Handshake: hold note_done=1 throughout, including ARM → next load occurs no earlier than 4 cycles after the previous load, and index increments by exactly 1 per note.
- End marker: song 1 word 3 has duration 0 → three loads, then song_done high 1 cycle, state IDLE; with play=1 held, the next load is note 0 of song 1.
- Full song: song 0 with all 32 durations nonzero → 32 loads, song_done after the 32nd note_done, and no rom_addr above 0x1F.
- Pause: drop play in WAIT_DONE while note_done=1 for 10 cycles → no FETCH and no load; raising play gives a load 3 cycles later.
- Song change and async reset: change song 0→3 in WAIT_DONE → rom_addr=0x60 next cycle, no song_done. Pulse reset_n low mid-LOAD → load_new_note drops immediately and all outputs are 0.

Source files
------------

// File: rtl/song_reader.sv
// song_reader: walks a synchronous song ROM one note at a time and hands each
// {note, duration} pair to the note player with a single-cycle load strobe.
// It waits for the player's done flag before fetching the next note, and
// flags end of song (32 notes, or an early zero-duration word) with a
// one-cycle song_done pulse.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   play              run/continue (1) or pause (0)
//   song[1:0]         song select; a change mid-song restarts at note 0
//   note_done         note player's done_with_note
//   rom_addr[6:0]     {song_l, note_index}, combinational from registers
//   rom_data[11:0]    {note[11:6], duration[5:0]}, valid 1 clock after rom_addr
//   note_to_load      registered note for the note player
//   duration_to_load  registered duration in beats
//   load_new_note     one-cycle load strobe, decoded from state
//   song_done         one-cycle registered end-of-song pulse
module song_reader #(
    parameter int unsigned NOTES_PER_SONG = 32,
    parameter int unsigned ROM_LATENCY    = 1
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    play,
    input  logic [1:0]                              song,
    input  logic                                    note_done,
    output logic [$clog2(NOTES_PER_SONG)+1:0]       rom_addr,
    input  logic [11:0]                             rom_data,
    output logic [5:0]                              note_to_load,
    output logic [5:0]                              duration_to_load,
    output logic                                    load_new_note,
    output logic                                    song_done
);

    localparam int unsigned IDX_W = $clog2(NOTES_PER_SONG);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOTES_PER_SONG - 1);

    // Only a single-cycle ROM is handled by the FETCH/DECODE pairing.
    if (ROM_LATENCY != 1) begin : g_bad_latency
        $error("song_reader: only ROM_LATENCY == 1 is supported");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        LOAD      = 3'd3,
        ARM       = 3'd4,
        WAIT_DONE = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       song_q, song_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [5:0]       note_q, note_d;
    logic [5:0]       dur_q, dur_d;
    logic             done_q, done_d;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            song_q  <= 2'd0;
            idx_q   <= '0;
            note_q  <= 6'd0;
            dur_q   <= 6'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            song_q  <= song_d;
            idx_q   <= idx_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        song_d  = song_q;
        idx_d   = idx_q;
        note_d  = note_q;
        dur_d   = dur_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                idx_d = '0;
                if (play) begin
                    song_d  = song;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                if (rom_data[5:0] == 6'd0) begin
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    note_d  = rom_data[11:6];
                    dur_d   = rom_data[5:0];
                    state_d = LOAD;
                end
            end
            LOAD: state_d = ARM;
            // note_done still reflects the previous note here; ignore it.
            ARM: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (note_done && play) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A new song select restarts from note 0 and overrides everything else.
        if (state_q != IDLE && song != song_q) begin
            song_d  = song;
            idx_d   = '0;
            note_d  = note_q;
            dur_d   = dur_q;
            done_d  = 1'b0;
            state_d = FETCH;
        end
    end

    assign rom_addr         = {song_q, idx_q};
    assign load_new_note    = (state_q == LOAD);
    assign note_to_load     = note_q;
    assign duration_to_load = dur_q;
    assign song_done        = done_q;

endmodule

// File: tb/tb_song_reader.sv
// Testbench for song_reader: cycle-table checks for start, handshake and song
// change, plus sequences for end marker, full song, pause and async reset.
module tb_song_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        play;
    logic [1:0]  song;
    logic        note_done;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data;
    logic [5:0]  note_to_load;
    logic [5:0]  duration_to_load;
    logic        load_new_note;
    logic        song_done;

    logic [11:0] rom [128];

    int total = 0;
    int bad   = 0;

    song_reader dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .play             (play),
        .song             (song),
        .note_done        (note_done),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .load_new_note    (load_new_note),
        .song_done        (song_done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with one clock of latency.
    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct {
        logic       play;
        logic [1:0] song;
        logic       nd;
        logic [6:0] addr;
        logic       load;
        logic [5:0] note;
        logic [5:0] dur;
        logic       done;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        play      = 1'b0;
        song      = 2'd0;
        note_done = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, int'(rom_addr), 0);
        chk({tag, "_load"}, int'(load_new_note), 0);
        chk({tag, "_note"}, int'(note_to_load), 0);
        chk({tag, "_dur"},  int'(duration_to_load), 0);
        chk({tag, "_done"}, int'(song_done), 0);
    endtask

    initial begin
        int n;
        int loads;
        int last;
        int maxaddr;
        int bad_cyc;
        int done_cycles;
        bit done_seen;

        // ROM: note = addr+5, duration = addr%5+1, with two hand-placed words.
        for (int a = 0; a < 128; a++)
            rom[a] = {6'(a + 5), 6'((a % 5) + 1)};
        rom[7'h40] = {6'd20, 6'd3};
        rom[7'h23] = {6'd9, 6'd0};

        // Start of song 2, handshake with note_done held, then change to song 3.
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 7'h40, 1'b0, 6'd0,  6'd0, 1'b0};
        vecs[1]  = '{1'b1, 2'd2, 1'b0, 7'h40, 1'b0, 6'd0,  6'd0, 1'b0};
        vecs[2]  = '{1'b1, 2'd2, 1'b0, 7'h40, 1'b1, 6'd20, 6'd3, 1'b0};
        vecs[3]  = '{1'b1, 2'd2, 1'b1, 7'h40, 1'b0, 6'd20, 6'd3, 1'b0};
        vecs[4]  = '{1'b1, 2'd2, 1'b1, 7'h40, 1'b0, 6'd20, 6'd3, 1'b0};
        vecs[5]  = '{1'b1, 2'd2, 1'b1, 7'h41, 1'b0, 6'd20, 6'd3, 1'b0};
        vecs[6]  = '{1'b1, 2'd2, 1'b1, 7'h41, 1'b0, 6'd20, 6'd3, 1'b0};
        vecs[7]  = '{1'b1, 2'd2, 1'b1, 7'h41, 1'b1, 6'd6,  6'd1, 1'b0};
        vecs[8]  = '{1'b1, 2'd2, 1'b0, 7'h41, 1'b0, 6'd6,  6'd1, 1'b0};
        vecs[9]  = '{1'b1, 2'd2, 1'b0, 7'h41, 1'b0, 6'd6,  6'd1, 1'b0};
        vecs[10] = '{1'b1, 2'd3, 1'b0, 7'h60, 1'b0, 6'd6,  6'd1, 1'b0};
        vecs[11] = '{1'b1, 2'd3, 1'b0, 7'h60, 1'b0, 6'd6,  6'd1, 1'b0};
        vecs[12] = '{1'b1, 2'd3, 1'b0, 7'h60, 1'b1, 6'd37, 6'd2, 1'b0};

        do_reset();
        chk_all_zero("reset");

        for (int i = 0; i < 13; i++) begin
            play      = vecs[i].play;
            song      = vecs[i].song;
            note_done = vecs[i].nd;
            step();
            chk($sformatf("v%0d_addr", i), int'(rom_addr), int'(vecs[i].addr));
            chk($sformatf("v%0d_load", i), int'(load_new_note), int'(vecs[i].load));
            chk($sformatf("v%0d_note", i), int'(note_to_load), int'(vecs[i].note));
            chk($sformatf("v%0d_dur", i), int'(duration_to_load), int'(vecs[i].dur));
            chk($sformatf("v%0d_done", i), int'(song_done), int'(vecs[i].done));
        end

        // End marker: song 1 word 3 has zero duration.
        do_reset();
        song = 2'd1; play = 1'b1; note_done = 1'b1;
        loads = 0; done_seen = 1'b0;
        for (int c = 0; c < 200 && !done_seen; c++) begin
            step();
            if (load_new_note) loads++;
            if (song_done) done_seen = 1'b1;
        end
        chk("eom_seen", int'(done_seen), 1);
        chk("eom_loads", loads, 3);
        chk("eom_idle_addr", int'(rom_addr), 'h20);
        step();
        chk("eom_done_width", int'(song_done), 0);
        n = 1;
        while (!load_new_note && n < 20) begin
            step();
            n++;
        end
        chk("eom_restart_lat", n, 3);
        chk("eom_restart_note", int'(note_to_load), 37);
        chk("eom_restart_dur", int'(duration_to_load), 3);

        // Full song 0: 32 loads, exact spacing, index steps by one.
        do_reset();
        song = 2'd0; play = 1'b1; note_done = 1'b1;
        loads = 0; last = 0; maxaddr = 0; done_seen = 1'b0; bad_cyc = 0;
        for (int c = 0; c < 400 && !done_seen; c++) begin
            step();
            if (int'(rom_addr) > maxaddr) maxaddr = int'(rom_addr);
            if (load_new_note) begin
                if (int'(rom_addr) != loads) bad_cyc++;
                if (note_to_load != rom[loads][11:6] || duration_to_load != rom[loads][5:0])
                    bad_cyc++;
                if (loads > 0 && c - last != 5) bad_cyc++;
                last = c;
                loads++;
            end
            if (song_done) done_seen = 1'b1;
        end
        play = 1'b0;
        chk("full_seen", int'(done_seen), 1);
        chk("full_loads", loads, 32);
        chk("full_maxaddr", maxaddr, 31);
        chk("full_seq_errors", bad_cyc, 0);

        // Pause in WAIT_DONE with note_done high.
        do_reset();
        song = 2'd3; play = 1'b1; note_done = 1'b0;
        n = 0;
        while (!load_new_note && n < 20) begin
            step();
            n++;
        end
        chk("pause_first_load", int'(load_new_note), 1);
        step();
        step();
        play = 1'b0; note_done = 1'b1;
        bad_cyc = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (load_new_note || rom_addr != 7'h60) bad_cyc++;
        end
        chk("pause_hold", bad_cyc, 0);
        play = 1'b1;
        n = 0;
        while (!load_new_note && n < 10) begin
            step();
            n++;
        end
        chk("pause_resume_lat", n, 3);
        chk("pause_resume_addr", int'(rom_addr), 'h61);

        // Async reset asserted during LOAD.
        chk("rst_in_load", int'(load_new_note), 1);
        #2 reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        play = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        chk_all_zero("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
